layer1_maxpool_reader: RTL
==========================

Name: layer1_maxpool_reader

Overview:
- Consumer of the layer-0 result memory: once layer-0 finishes writing its 64x64 feature map, this block reads the map back.
- Applies 2x2, stride-2 signed max pooling and writes a 32x32 map to the layer-1 memory.
- Sits downstream of the convolution stage and is started by its finish pulse.
- Memory read port is synchronous: 1-cycle read latency.

Parameters:
- DW, 20, pixel data width (signed two's complement fixed point).
- IMG_W_LOG2, 6, log2 of input image width/height (64); output is 2^(IMG_W_LOG2-1) square.
- AW_IN, 12, read address width (2*IMG_W_LOG2).
- AW_OUT, 10, write address width (2*(IMG_W_LOG2-1)).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  one-cycle pulse (layer-0 finish); ignored unless in IDLE.
- crd  output  1  read strobe to layer-0 memory.
- caddr_rd  output  AW_IN  read address, row-major (addr = row*64 + col).
- cdata_rd  input  DW  read data; valid the cycle after crd=1.
- cwr1  output  1  write strobe to layer-1 memory.
- caddr_wr1  output  AW_OUT  write address, row-major in the 32x32 map.
- cdata_wr1  output  DW  pooled pixel.
- busy  output  1  high from the cycle after start is accepted until the final write has issued.
- done  output  1  level; high after the final write, cleared by the next accepted start or by reset.

Behaviour:
- Reset values: crd=0, caddr_rd=0, cwr1=0, caddr_wr1=0, cdata_wr1=0, busy=0, done=0. Internal state: FSM=IDLE, px=py=0, max_reg=0.
- Window counters: px, py, each IMG_W_LOG2-1 bits.
- Read address = {py, dy, px, dx}, where dy/dx select the window element:
  - RD0: dy=0, dx=0
  - RD1: dy=0, dx=1
  - RD2: dy=1, dx=0
  - RD3: dy=1, dx=1
- FSM states: IDLE, RD0, RD1, RD2, RD3, WR, FIN.
- IDLE:
  - start=1 -> RD0; px=py=0; done<=0.
  - Otherwise stay.
- RD0..RD3:
  - crd=1 and caddr_rd as above; advance one state per cycle.
  - Data sampling:
    - RD1: max_reg<=cdata_rd (d0, no compare).
    - RD2 and RD3: max_reg<=signed max(max_reg, cdata_rd).
- WR:
  - crd=0; d3 arrives on cdata_rd.
  - Registered outputs: cwr1<=1, cdata_wr1<=signed max(max_reg, cdata_rd), caddr_wr1<={py,px}.
  - Then advance px; on px wrap (31->0) increment py.
  - If {py,px} was all ones -> FIN, else -> RD0.
- Write pulse timing: cwr1 is high exactly one cycle (the cycle after WR), overlapping the next RD0. It is low in all other cycles.
- Throughput: 5 cycles per output pixel. Total: 1024*5 cycles from the first RD0 to the last WR.
- FIN:
  - The final write pulse is visible in this cycle.
  - busy<=0, done<=1; next state IDLE.
  - done holds until the next start is accepted.
- Comparison rule: full DW-bit signed compare. On a tie, either operand (identical value) is written. No saturation, no rounding; the output width equals the input width.
- start while busy: ignored; no restart and no state change.
- start in the same cycle as the FIN->IDLE transition: ignored. It is accepted only from IDLE.
- Reset mid-operation: all outputs and state return to reset values immediately (asynchronous). Partial windows are discarded; no write is issued for them.
- cdata_rd is sampled only in the cycles RD1, RD2, RD3, WR. Its value at any other time has no effect.

Test Plan:
- Ramp map (mem[a]=a), pulse start -> 1024 cwr1 pulses; caddr_wr1 runs 0..1023 in order; cdata_wr1 at out addr k = 2*64*(k/32) + 2*(k%32) + 65 (e.g. k=0 -> 65, k=1023 -> 4095); done rises 1 cycle after the last pulse; cwr1 pulses exactly 5 cycles apart.
- Signed handling: window {0xFFFFF(-1), 0x80000(min), 0x00001, 0x7FFFF(max)} -> 0x7FFFF. All-negative window {0xF0000, 0xFFFFE, 0x80000, 0xF7295} -> 0xFFFFE.
- Tie/zero: window of four equal values 0x01310 -> 0x01310. All-zero map -> every write 0.
- Address pattern: check the crd/caddr_rd sequence for output (px=31, py=0) is 62, 63, 126, 127; for (31, 31) it is 4030, 4031, 4094, 4095.
- Reset asserted mid-run (after 100 writes) -> crd=cwr1=busy=done=0 immediately. A new start then restarts at caddr_rd=0 with caddr_wr1 sequence from 0.
- start pulsed during busy and again in the FIN cycle -> no effect. start after done=1 -> done clears and a full second pass produces identical results.

Source files
------------

// File: rtl/layer1_maxpool_reader.sv
// Reads the 64x64 layer-0 map back, applies a 2x2 stride-2 signed max-pool,
// and writes the resulting 32x32 map to layer-1 memory, one pixel per 5 cycles.
module layer1_maxpool_reader #(
  parameter int DW         = 20,
  parameter int IMG_W_LOG2 = 6,
  parameter int AW_IN      = 2*IMG_W_LOG2,
  parameter int AW_OUT     = 2*(IMG_W_LOG2-1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              crd,
  output logic [AW_IN-1:0]  caddr_rd,
  input  logic [DW-1:0]     cdata_rd,
  output logic              cwr1,
  output logic [AW_OUT-1:0] caddr_wr1,
  output logic [DW-1:0]     cdata_wr1,
  output logic              busy,
  output logic              done
);
  localparam int CW = IMG_W_LOG2-1;

  typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_WR, S_FIN} state_t;

  state_t               state, nstate;
  logic [CW-1:0]        px, py;
  logic signed [DW-1:0] max_reg;
  logic signed [DW-1:0] sel_max;
  logic                 dy, dx;

  assign sel_max  = ($signed(cdata_rd) > max_reg) ? $signed(cdata_rd) : max_reg;
  assign caddr_rd = {py, dy, px, dx};

  always_comb begin
    nstate = state;
    crd    = 1'b0;
    dy     = 1'b0;
    dx     = 1'b0;
    case (state)
      S_IDLE: if (start) nstate = S_RD0;
      S_RD0: begin crd = 1'b1; nstate = S_RD1; end
      S_RD1: begin crd = 1'b1; dx = 1'b1; nstate = S_RD2; end
      S_RD2: begin crd = 1'b1; dy = 1'b1; nstate = S_RD3; end
      S_RD3: begin crd = 1'b1; dy = 1'b1; dx = 1'b1; nstate = S_WR; end
      S_WR:  nstate = (&{py, px}) ? S_FIN : S_RD0;
      S_FIN: nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      px        <= '0;
      py        <= '0;
      max_reg   <= '0;
      cwr1      <= 1'b0;
      caddr_wr1 <= '0;
      cdata_wr1 <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= nstate;
      // Write strobe lasts exactly the one cycle following WR.
      cwr1  <= (state == S_WR);
      case (state)
        S_IDLE: if (start) begin
          px   <= '0;
          py   <= '0;
          done <= 1'b0;
          busy <= 1'b1;
        end
        S_RD1: max_reg <= $signed(cdata_rd);
        S_RD2, S_RD3: max_reg <= sel_max;
        S_WR: begin
          cdata_wr1 <= sel_max;
          caddr_wr1 <= {py, px};
          px        <= px + 1'b1;
          if (&px) py <= py + 1'b1;
        end
        S_FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
